// File: rtl/pool_sched.sv
// pool_sched: sequences the 2x2 max-pool buffer. Streams 8-word groups of
// conv words into the buffer, writes the 64-bit pool result to the output
// SRAM after the 6th and 8th word of each group, and runs a programmed
// number of groups per frame.
module pool_sched #(
  parameter int ADDR_W = 10,
  parameter int GRP_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GRP_W-1:0]  cfg_groups,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              up_valid,
  input  logic [31:0]       up_data,
  output logic              up_ready,
  output logic              pb_valid,
  output logic [31:0]       pb_conv,
  input  logic [3:0]        pb_count,
  input  logic [63:0]       pb_pool,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WR6,
    S_WR8,
    S_FIN
  } state_t;

  state_t            state_q;
  logic              up_ready_q;
  logic              wr_en_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              chk_q;      // first cycle of a WR state: buffer count is valid to check
  logic [3:0]        wcnt_q;
  logic [GRP_W-1:0]  grp_q;
  logic [GRP_W-1:0]  groups_q;
  logic [ADDR_W-1:0] addr_q;

  logic              accept;
  logic              wr_fire;
  logic [3:0]        wcnt_d;
  logic [GRP_W-1:0]  grp_d;

  assign accept  = up_valid & up_ready_q;
  assign wr_fire = wr_en_q & wr_ready;
  assign wcnt_d  = wcnt_q + 4'd1;
  assign grp_d   = grp_q + GRP_W'(1);

  // Datapath is a straight pass-through; the controller only gates strobes.
  assign up_ready = up_ready_q;
  assign pb_valid = accept;
  assign pb_conv  = up_data;
  assign wr_en    = wr_en_q;
  assign wr_addr  = addr_q;
  assign wr_data  = pb_pool;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

  // Frame FSM with registered handshake/status outputs and group bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: every register in a clocked block uses <= so all of them see
      // the pre-edge values of each other, regardless of statement order.
      state_q    <= S_IDLE;
      up_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      chk_q      <= 1'b0;
      wcnt_q     <= '0;
      grp_q      <= '0;
      groups_q   <= '0;
      addr_q     <= '0;
    end else begin
      done_q <= 1'b0;
      chk_q  <= 1'b0;

      // The buffer has just counted the word that triggered the write.
      if (chk_q && (((state_q == S_WR6) && (pb_count != 4'd6)) ||
                    ((state_q == S_WR8) && (pb_count != 4'd8)))) begin
        err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            groups_q <= cfg_groups;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            if (cfg_groups == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FILL;
              up_ready_q <= 1'b1;
              wcnt_q     <= '0;
              grp_q      <= '0;
              addr_q     <= cfg_base;
            end
          end
        end

        S_FILL: begin
          if (accept) begin
            wcnt_q <= wcnt_d;
            if (wcnt_d == 4'd6) begin
              state_q    <= S_WR6;
              up_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              chk_q      <= 1'b1;
            end else if (wcnt_d == 4'd8) begin
              state_q    <= S_WR8;
              up_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              chk_q      <= 1'b1;
            end
          end
        end

        S_WR6: begin
          if (wr_fire) begin
            addr_q     <= addr_q + ADDR_W'(1);
            wr_en_q    <= 1'b0;
            up_ready_q <= 1'b1;
            state_q    <= S_FILL;
          end
        end

        // No pb_valid here: this is the buffer's clear cycle.
        S_WR8: begin
          if (wr_fire) begin
            addr_q  <= addr_q + ADDR_W'(1);
            wr_en_q <= 1'b0;
            wcnt_q  <= '0;
            grp_q   <= grp_d;
            if (grp_d == groups_q) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q    <= S_FILL;
              up_ready_q <= 1'b1;
            end
          end
        end

        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          up_ready_q <= 1'b0;
          wr_en_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_sched.sv
// Testbench for pool_sched: pool-buffer model, upstream word driver and a
// scoreboard monitor that checks every SRAM write and done pulse.
module tb_pool_sched;

  localparam int ADDR_W = 10;
  localparam int GRP_W  = 12;

  logic              clk;
  logic              rst;
  logic              start;
  logic [GRP_W-1:0]  cfg_groups;
  logic [ADDR_W-1:0] cfg_base;
  logic              up_valid;
  logic [31:0]       up_data;
  logic              up_ready;
  logic              pb_valid;
  logic [31:0]       pb_conv;
  logic [3:0]        pb_count;
  logic [63:0]       pb_pool;
  logic              wr_en;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              busy;
  logic              done;
  logic              err;

  pool_sched #(.ADDR_W(ADDR_W), .GRP_W(GRP_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_groups(cfg_groups), .cfg_base(cfg_base),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .pb_valid(pb_valid), .pb_conv(pb_conv),
    .pb_count(pb_count), .pb_pool(pb_pool),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pool buffer model: counts strobes, clears after an idle cycle at 8, and
  // presents {previous word, last word} as its result.
  logic [3:0]  mcnt;
  logic [31:0] m_last, m_prev;
  logic        force_cnt;
  always @(posedge clk) begin
    if (!rst) begin
      mcnt   <= '0;
      m_last <= '0;
      m_prev <= '0;
    end else if (pb_valid) begin
      mcnt   <= mcnt + 4'd1;
      m_last <= pb_conv;
      m_prev <= m_last;
    end else if (mcnt == 4'd8) begin
      mcnt <= '0;
    end
  end
  assign pb_count = force_cnt ? 4'd5 : mcnt;
  assign pb_pool  = {m_prev, m_last};

  // Scoreboard
  typedef struct {
    bit                is_done;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } exp_t;
  exp_t exp_q[$];
  int   wr_cyc[$];
  int   wr_cnt, done_cnt, pbv_cnt, done_cyc, t0;
  bit   rdy_seen;

  function automatic logic [31:0] word(input int idx);
    logic [7:0] b;
    b = 8'((idx / 8) * 16 + (idx % 8) + 1);
    return {4{b}};
  endfunction

  task automatic push_groups(input int ngrp, input logic [ADDR_W-1:0] base);
    exp_t e;
    for (int g = 0; g < ngrp; g++) begin
      e.is_done = 1'b0;
      e.addr = base + ADDR_W'(2 * g);
      e.data = {word(8 * g + 4), word(8 * g + 5)};
      exp_q.push_back(e);
      e.addr = base + ADDR_W'(2 * g + 1);
      e.data = {word(8 * g + 6), word(8 * g + 7)};
      exp_q.push_back(e);
    end
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1;
    e.addr = '0;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every write handshake and done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (pb_valid) pbv_cnt++;
      if (up_ready) rdy_seen = 1'b1;
      if (wr_en) begin
        check("wr_cycle_up_ready_low", up_ready, 0);
        check("wr_cycle_pb_valid_low", pb_valid, 0);
      end
      if (wr_en && wr_ready) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_kind", e.is_done, 0);
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("done_kind", e.is_done, 1);
        end
      end
    end
  end

  task automatic clear_stats();
    wr_cnt = 0; done_cnt = 0; pbv_cnt = 0; done_cyc = -1; rdy_seen = 1'b0;
    wr_cyc.delete();
  endtask

  // All stimulus tasks start and end at posedge+#1.
  task automatic pulse_start(input int groups, input logic [ADDR_W-1:0] base);
    cfg_groups = GRP_W'(groups);
    cfg_base   = base;
    start      = 1'b1;
    t0         = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int total, input bit toggle);
    int  idx = 0;
    int  guard = 0;
    bit  ph = 1'b1;
    bit  acc;
    while (idx < total && guard < 2000) begin
      up_valid = toggle ? ph : 1'b1;
      up_data  = word(idx);
      @(negedge clk);
      acc = up_valid && up_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      ph = ~ph;
      guard++;
    end
    up_valid = 1'b0;
    check("words_accepted", idx, total);
  endtask

  task automatic wait_done(output logic err_at_done);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 500);
    check("done_seen", done, 1);
    err_at_done = err;
    @(posedge clk); #1;
  endtask

  task automatic stall_watch();
    int k = 0;
    logic [ADDR_W-1:0] a0;
    logic [63:0]       d0;
    do begin
      @(negedge clk);
      k++;
    end while (!wr_en && k < 500);
    check("stall_wr_en_seen", wr_en, 1);
    a0 = wr_addr;
    d0 = wr_data;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("stall_wr_en_held", wr_en, 1);
      check("stall_wr_addr_held", wr_addr, a0);
      check("stall_wr_data_held", wr_data, d0);
    end
    @(posedge clk); #1;
    wr_ready = 1'b1;
  endtask

  task automatic run_frame(input int groups, input logic [ADDR_W-1:0] base,
                           input bit toggle, input bit stall);
    logic e;
    clear_stats();
    push_groups(groups, base);
    push_done();
    wr_ready = !stall;
    if (stall) begin
      fork
        stall_watch();
      join_none
    end
    pulse_start(groups, base);
    check("err_clear_after_start", err, 0);
    check("busy_after_start", busy, 1);
    send_words(8 * groups, toggle);
    wait_done(e);
    check("frame_scoreboard_empty", exp_q.size(), 0);
    check("frame_write_count", wr_cnt, 2 * groups);
    check("frame_done_count", done_cnt, 1);
    check("frame_pb_valid_count", pbv_cnt, 8 * groups);
    check("idle_after_done", busy, 0);
    wr_ready = 1'b1;
  endtask

  initial begin
    logic e;
    rst = 1'b0; start = 1'b0; cfg_groups = '0; cfg_base = '0;
    up_valid = 1'b0; up_data = '0; wr_ready = 1'b1; force_cnt = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {up_ready, pb_valid, wr_en, busy, done, err}, 0);
    check("rst_wr_addr", wr_addr, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // One group, back-to-back words, write/done timing
    run_frame(1, 10'h010, 1'b0, 1'b0);
    check("t1_first_write_cycle", wr_cyc.size() > 0 ? wr_cyc[0] - t0 : -1, 7);
    check("t1_second_write_cycle", wr_cyc.size() > 1 ? wr_cyc[1] - t0 : -1, 10);
    check("t1_done_cycle", done_cyc - t0, 11);
    check("t1_pb_count_cleared", pb_count, 0);

    // Three groups with a toggling up_valid
    run_frame(3, 10'h100, 1'b1, 1'b0);

    // Two groups, SRAM stalls the first write for 5 cycles
    run_frame(2, 10'h200, 1'b0, 1'b1);

    // Empty frame
    run_frame(0, 10'h300, 1'b0, 1'b0);
    check("t4_done_next_cycle", done_cyc - t0, 1);
    check("t4_no_up_ready", rdy_seen, 0);

    // Reset after the 3rd word of the second group aborts the frame
    clear_stats();
    push_groups(1, 10'h020);
    pulse_start(2, 10'h020);
    send_words(11, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_outputs", {up_ready, pb_valid, wr_en, busy, done, err}, 0);
    check("abort_wr_addr", wr_addr, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_writes", wr_cnt, 2);
    check("abort_no_done", done_cnt, 0);
    check("abort_scoreboard_empty", exp_q.size(), 0);

    // Full frame after the abort, with the address wrapping past 0x3FF
    run_frame(2, 10'h3FE, 1'b0, 1'b0);

    // Forced count mismatch at WR6 entry sets sticky err
    clear_stats();
    push_groups(1, 10'h040);
    push_done();
    force_cnt = 1'b1;
    pulse_start(1, 10'h040);
    fork
      begin
        int k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!wr_en && k < 500);
        @(posedge clk); #1;
        force_cnt = 1'b0;
        @(negedge clk);
        check("err_set_after_wr6", err, 1);
      end
    join_none
    send_words(8, 1'b0);
    wait_done(e);
    check("err_held_at_done", e, 1);
    check("err_held_after_done", err, 1);
    check("err_frame_scoreboard_empty", exp_q.size(), 0);

    // Next start clears err (checked inside run_frame)
    run_frame(1, 10'h050, 1'b0, 1'b0);
    check("err_stays_clear", err, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_sched.md
Name: pool_sched

Overview:
Controller that sequences the 2x2 max-pool buffer (32-bit conv word in, 64-bit pool word out, 4-bit group count). It accepts conv words from the convolution engine over a valid/ready handshake and forwards them to the pool buffer as valid strobes. After the 6th and 8th word of each 8-word group, it writes the pool buffer's 64-bit result to the output feature-map SRAM. It inserts the idle cycle the buffer needs to clear its count, and runs a programmed number of groups per frame.

Parameters:
ADDR_W, 10, output SRAM word-address width
GRP_W, 12, width of the group-count configuration

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
start  in  1  one-cycle pulse that begins a frame; ignored while busy
cfg_groups  in  GRP_W  number of 8-word groups in the frame; latched on start
cfg_base  in  ADDR_W  first output address; latched on start
up_valid  in  1  conv engine word valid
up_data  in  32  conv word (4 x 8-bit channels)
up_ready  out  1  controller accepts word
pb_valid  out  1  valid strobe to the pool buffer
pb_conv  out  32  word to the pool buffer
pb_count  in  4  pool buffer group count
pb_pool  in  64  pool buffer result
wr_en  out  1  SRAM write request
wr_ready  in  1  SRAM accepts write
wr_addr  out  ADDR_W  SRAM address
wr_data  out  64  SRAM data
busy  out  1  frame in progress
done  out  1  one-cycle pulse at frame end
err  out  1  sticky: pb_count disagrees with internal word count

Behaviour:
- Reset values (rst==0): state IDLE; up_ready, pb_valid, wr_en, busy, done, err = 0; wr_addr = 0; internal counters = 0. Reset mid-frame aborts the frame and issues no done pulse.
- States:
  - IDLE: on start, latch cfg. If cfg_groups==0, go to FIN. Otherwise go to FILL with wcnt=0, grp=0, wr_addr=cfg_base.
  - FILL: up_ready=1. pb_valid = up_valid & up_ready (combinational). pb_conv = up_data (combinational, every state). Each accepted word increments wcnt.
    - Acceptance that brings wcnt to 6: go to WR6.
    - Acceptance that brings wcnt to 8: go to WR8.
  - WR6: up_ready=0, pb_valid=0, wr_en=1, wr_data=pb_pool (combinational). Hold until wr_ready. On wr_en & wr_ready: wr_addr+1, return to FILL.
  - WR8: same as WR6. pb_valid=0 here gives the buffer its clear cycle (count 8 -> 0). On handshake: wr_addr+1, wcnt=0, grp+1.
    - If grp+1 == cfg_groups, go to FIN.
    - Otherwise go to FILL.
  - FIN: done=1 for exactly one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - First write appears the cycle after the 6th accepted word.
  - Minimum group time is 10 cycles (8 accepts + 2 writes).
  - wr_ready stall holds wr_en, wr_addr and wr_data stable.
- Consistency check: on entry to WR6, pb_count must equal 6; on entry to WR8, it must equal 8. Otherwise set err=1. err clears only on reset or start.
- wr_addr wraps modulo 2^ADDR_W with no error.
- Writes per frame = 2*cfg_groups. Addresses run cfg_base .. cfg_base+2*cfg_groups-1.
- start during busy has no effect. start in the same cycle as rst==0 is ignored.
- up_valid while up_ready==0: the word is held by the upstream engine, not dropped.

Test Plan:
- cfg_groups=1, cfg_base=0x10, words 0x01010101..0x08080808 streamed back-to-back, wr_ready=1 -> wr_en at cycles 7 and 10 with wr_addr 0x10 then 0x11; wr_data equals pb_pool at each write; done pulses at cycle 11; pb_count back to 0.
- cfg_groups=3, up_valid toggling 1/0 each cycle -> 6 writes at addresses base..base+5; exactly one done; up_ready low during every WR cycle.
- cfg_groups=2, wr_ready held low 5 cycles during the first WR6 -> wr_en, wr_addr and wr_data stable for 5 cycles; no extra pb_valid; 4 writes total.
- cfg_groups=0 -> done the cycle after start; no wr_en; no up_ready.
- rst=0 asserted after the 3rd word of group 2 -> next cycle all outputs at reset values; a subsequent start runs a full frame correctly.
- Force pb_count=5 at WR6 entry -> err=1 and stays set through done; cleared by the next start.
